// File: rtl/shader_pkg.sv
// shader_pkg: vector field widths, framebuffer geometry and the clamp-and-pack
// helper shared between the dispatcher and the Lambert shader.
package shader_pkg;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int ZW = 9;
  localparam int VW = XW + YW + ZW;
  localparam int AW = 19;
  localparam int CW = 12;
  localparam int SHADE_LAT = 4;
  function automatic logic [10:0] clamp(input logic signed [16:0] v, input logic signed [16:0] lim);
    return v > lim ? 11'(lim) : v < ~lim ? 11'(~lim) : 11'(v);
  endfunction
  function automatic logic [VW-1:0] sat_pack(input logic signed [16:0] x, y, z);
    return {clamp(x, 17'sd1023), clamp(y, 17'sd1023), ZW'(clamp(z, 17'sd255))};
  endfunction
endpackage

// File: rtl/shade_result_fifo.sv
// shade_result_fifo: synchronous FIFO holding {addr, color} results awaiting the framebuffer.
module shade_result_fifo #(
  parameter int WIDTH = shader_pkg::VW,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  assign count = wp - rp;
  assign empty = wp == rp;
  // Head reads as zero when empty so the write bus is quiet in and after reset.
  assign dout = empty ? '0 : mem[rp[PW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= din;
endmodule

// File: rtl/shade_dispatcher.sv
// shade_dispatcher: feeds the Lambert shader, tags its fixed-latency results with
// pixel addresses and emits in-order framebuffer writes under credit flow control.
module shade_dispatcher #(
  parameter int SHADE_LAT = shader_pkg::SHADE_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter logic signed [15:0] LIGHT_X = 16'sd0,
  parameter logic signed [15:0] LIGHT_Y = 16'sd0,
  parameter logic signed [15:0] LIGHT_Z = 16'sd1000,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic clk,
  input  logic rst,
  input  logic hit_valid,
  output logic hit_ready,
  input  logic [15:0] hit_px,
  input  logic [15:0] hit_py,
  input  logic [15:0] hit_pz,
  input  logic [15:0] hit_nx,
  input  logic [15:0] hit_ny,
  input  logic [15:0] hit_nz,
  input  logic [18:0] hit_addr,
  input  logic hit_miss,
  output logic [30:0] normal,
  output logic [30:0] orient,
  input  logic [11:0] color_in,
  output logic fb_valid,
  input  logic fb_ready,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data
);
  import shader_pkg::*;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  logic accept, push, pop, empty;
  logic [OW-1:0] outstanding, fifo_count;
  logic [SHADE_LAT-1:0] tag_v, tag_m;
  logic [SHADE_LAT-1:0][AW-1:0] tag_a;
  logic [VW-1:0] head;
  // Credits cover both in-flight tags and queued results, so the FIFO can never overflow.
  assign hit_ready = rst && outstanding < OW'(FIFO_DEPTH);
  assign accept = hit_valid && hit_ready;
  assign push = tag_v[SHADE_LAT-1];
  assign pop = fb_valid && fb_ready;
  assign fb_valid = !empty;
  assign {fb_addr, fb_data} = head;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag_v <= '0;
      normal <= '0;
      orient <= '0;
      outstanding <= '0;
    end else begin
      tag_v <= {tag_v[SHADE_LAT-2:0], accept};
      outstanding <= outstanding + OW'(accept) - OW'(pop);
      if (accept) begin
        normal <= sat_pack(17'(signed'(hit_nx)), 17'(signed'(hit_ny)), 17'(signed'(hit_nz)));
        orient <= sat_pack(17'(LIGHT_X) - 17'(signed'(hit_px)),
                           17'(LIGHT_Y) - 17'(signed'(hit_py)),
                           17'(LIGHT_Z) - 17'(signed'(hit_pz)));
      end
      assert (!(push && !pop && fifo_count == OW'(FIFO_DEPTH)));
    end
  always_ff @(posedge clk) begin
    tag_a <= {tag_a[SHADE_LAT-2:0], hit_addr};
    tag_m <= {tag_m[SHADE_LAT-2:0], hit_miss};
  end
  shade_result_fifo #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({tag_a[SHADE_LAT-1], tag_m[SHADE_LAT-1] ? BG_COLOR : color_in}),
    .dout(head),
    .empty(empty),
    .count(fifo_count)
  );
endmodule
